encoder_32_to_5: RTL and testbench

- Registered 32-to-5 binary encoder; converts a 32-bit one-hot (or arbitrary) request vector into the 5-bit index of the highest set bit.
- Used wherever a one-hot select/grant bus must be compressed into a binary index, e.g. after an arbiter or decoder stage.
- Also produces a valid flag and, optionally, a multi-hot error flag.
- One clock domain, single pipeline register, 1-cycle latency.

---
 rtl/encoder_32_to_5_if.sv | 25 ++
 rtl/encoder_32_to_5.sv | 63 ++++++
 tb/tb_encoder_32_to_5.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/encoder_32_to_5_if.sv
// Request/index bundle for the 32-to-5 encoder: request vector in, registered index and flags out.
// The master modport drives the request; the slave modport (the encoder) returns the index.
interface encoder_32_to_5_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 5
);
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] out;
    logic             valid;
    logic             multi_hot;

    modport master (
        output in,
        input  out,
        input  valid,
        input  multi_hot
    );

    modport slave (
        input  in,
        output out,
        output valid,
        output multi_hot
    );
endinterface

// File: rtl/encoder_32_to_5.sv
// Registered MSB-priority 32-to-5 encoder with valid flag; multi-hot detection under ENC_MULTIHOT_DET_EN.
// Latency 1 cycle; no backpressure, the request vector is sampled on every rising clk edge.
module encoder_32_to_5 #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    encoder_32_to_5_if.slave    s_if
);

    logic [OUT_W-1:0] w_idx;
    logic             w_any;

    logic [OUT_W-1:0] r_out;
    logic             r_valid;

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (s_if.in[i]) begin
                w_idx = OUT_W'(i);
            end
        end
    end

    assign w_any = |s_if.in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_out   <= w_idx;
            r_valid <= w_any;
        end
    end

    assign s_if.out   = r_out;
    assign s_if.valid = r_valid;

`ifdef ENC_MULTIHOT_DET_EN
    logic w_multi;
    logic r_multi;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(s_if.in & (s_if.in - IN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_multi <= 1'b0;
        end else begin
            r_multi <= w_multi;
        end
    end

    assign s_if.multi_hot = r_multi;
`else
    assign s_if.multi_hot = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_32_to_5.sv
// Self-checking bench for encoder_32_to_5: reset, vector table, one-hot walk, latency, mid-run reset, random.
module tb_encoder_32_to_5;

    logic clk;
    logic rst;

    encoder_32_to_5_if #(.IN_W(32), .OUT_W(5)) enc_if ();

    encoder_32_to_5 #(.IN_W(32), .OUT_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (enc_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] vin;
        logic [4:0]  exp_out;
        logic        exp_valid;
        logic        exp_multi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

`ifdef ENC_MULTIHOT_DET_EN
    localparam logic MH_EN = 1'b1;
`else
    localparam logic MH_EN = 1'b0;
`endif

    // Reference: highest set bit by downward search, multi-hot by population count.
    function automatic vec_t model(input logic [31:0] v);
        vec_t r;
        r.vin       = v;
        r.exp_out   = 5'd0;
        r.exp_valid = (v != 32'h0);
        r.exp_multi = MH_EN && ($countones(v) >= 2);
        for (int k = 31; k >= 0; k--) begin
            if (v[k] && r.exp_out == 5'd0 && (v >> (k + 1)) == 32'h0) begin
                r.exp_out = 5'(k);
            end
        end
        return r;
    endfunction

    task automatic check_outputs(input string name, input vec_t e);
        check({name, ".out"},       32'(enc_if.out),       32'(e.exp_out));
        check({name, ".valid"},     32'(enc_if.valid),     32'(e.exp_valid));
        check({name, ".multi_hot"}, 32'(enc_if.multi_hot), 32'(e.exp_multi));
    endtask

    // Drive on the falling edge, let one rising edge sample, check on the next falling edge.
    task automatic apply_and_check(input string name, input vec_t e);
        enc_if.in = e.vin;
        @(posedge clk);
        @(negedge clk);
        check_outputs(name, e);
    endtask

    vec_t table_v [8];
    vec_t zero_e;

    initial begin
        zero_e.vin = 32'h0; zero_e.exp_out = 5'd0; zero_e.exp_valid = 1'b0; zero_e.exp_multi = 1'b0;

        table_v[0] = '{32'h0000_0000, 5'd0,  1'b0, 1'b0};
        table_v[1] = '{32'h0000_0001, 5'd0,  1'b1, 1'b0};
        table_v[2] = '{32'h0000_0006, 5'd2,  1'b1, MH_EN};
        table_v[3] = '{32'h8000_0001, 5'd31, 1'b1, MH_EN};
        table_v[4] = '{32'hFFFF_FFFF, 5'd31, 1'b1, MH_EN};
        table_v[5] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0};
        table_v[6] = '{32'h0001_0000, 5'd16, 1'b1, 1'b0};
        table_v[7] = '{32'h0000_F0F0, 5'd15, 1'b1, MH_EN};

        // Reset held from time zero: outputs clear before any clock edge.
        rst       = 1'b1;
        enc_if.in = 32'hFFFF_FFFF;
        #1;
        check_outputs("reset_at_start", zero_e);
        @(negedge clk);
        rst = 1'b0;

        // Load all-ones, then assert reset between edges and look before the next edge.
        @(posedge clk);
        @(negedge clk);
        check("preset_out", 32'(enc_if.out), 32'd31);
        #1 rst = 1'b1;
        #1;
        check_outputs("async_reset", zero_e);
        @(posedge clk);
        #1;
        check_outputs("reset_held", zero_e);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_and_check($sformatf("table%0d", i), table_v[i]);
        end

        for (int k = 0; k < 32; k++) begin
            vec_t e;
            e = model(32'h1 << k);
            check($sformatf("walk_model%0d", k), 32'(e.exp_out), 32'(k));
            apply_and_check($sformatf("walk%0d", k), e);
        end

        // Latency: a change between edges must not reach the output until the next edge.
        apply_and_check("lat_first", model(32'h10));
        enc_if.in = 32'h400;
        #2;
        check("lat_hold_out", 32'(enc_if.out), 32'd4);
        @(posedge clk);
        #1;
        check("lat_after_edge", 32'(enc_if.out), 32'd10);
        @(negedge clk);

        // Stability: constant input keeps outputs constant over several edges.
        for (int s = 0; s < 3; s++) begin
            apply_and_check($sformatf("stable%0d", s), model(32'h0024_0000));
        end

        // Mid-run reset pulse shorter than a clock period; the pending sample is dropped.
        apply_and_check("midrst_pre", model(32'h8000_0000));
        enc_if.in = 32'h100;
        rst = 1'b1;
        #1;
        check_outputs("midrst_pulse", zero_e);
        #2 rst = 1'b0;
        #1;
        check("midrst_released_out", 32'(enc_if.out), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_first_out", 32'(enc_if.out), 32'd8);
        check("midrst_first_valid", 32'(enc_if.valid), 32'd1);
        @(negedge clk);

        // Random vectors of varying density.
        for (int r = 0; r < 300; r++) begin
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0: v = $urandom();
                1: v = 32'h1 << $urandom_range(0, 31);
                2: v = $urandom() & $urandom() & $urandom() & $urandom();
                default: v = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom() >> $urandom_range(0, 31));
            endcase
            apply_and_check($sformatf("rand%0d_%08h", r, v), model(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
